// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and latch record layout for the front-end pipeline
//   Contents: default NOP / reset PC, opcode constants, stage_t {ir, pc, valid},
//   bubble builder and load-opcode helper.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

    // Opcode field is instr[31:27]
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    function automatic stage_t make_bubble(input logic [31:0] nop);
        stage_t s;
        s.ir    = nop;
        s.pc    = 32'h0;
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return instr[31:27] == OP_LW;
    endfunction

endpackage

// File: rtl/pipe_latch.sv
// rtl/pipe_latch.sv - width-parameterised pipeline latch with load enable and bubble clear
//   Ports: clk_i, rst_i (async active-high), en_i (load d_i), clr_i (load CLR_VAL,
//   wins over en_i), d_i [W], q_o [W].
module pipe_latch #(
    parameter int             W       = 65,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= CLR_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fd_dx_pipe.sv
// rtl/fd_dx_pipe.sv - PC, F/D and D/X latches with freeze / redirect / stall / advance control
//   Inputs : clock, reset (async active-high), is_stall, md_busy, branch_taken,
//            branch_target[32], imem_q[32]
//   Outputs: pc_out, fd_ir/fd_pc/fd_valid, dx_ir/dx_pc/dx_valid, stall_cnt, flush_cnt
module fd_dx_pipe
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_stall,
    input  logic             md_busy,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_q,
    output logic [31:0]      pc_out,
    output logic [31:0]      fd_ir,
    output logic [31:0]      fd_pc,
    output logic             fd_valid,
    output logic [31:0]      dx_ir,
    output logic [31:0]      dx_pc,
    output logic             dx_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam stage_t BUBBLE = make_bubble(NOP_INSTR);

    // One-hot action decode; freeze dominates everything, redirect beats stall.
    logic act_redirect;
    logic act_stall;
    logic act_advance;

    assign act_redirect = !md_busy && branch_taken;
    assign act_stall    = !md_busy && !branch_taken && is_stall;
    assign act_advance  = !md_busy && !branch_taken && !is_stall;

    // Program counter (word address, natural 32-bit wrap)
    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (act_redirect) begin
            pc_d = branch_target;
        end else if (act_advance) begin
            pc_d = pc_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Pipeline latches
    stage_t fd_d, fd_q, dx_q;

    always_comb begin
        fd_d       = BUBBLE;
        fd_d.ir    = imem_q;
        fd_d.pc    = pc_q;
        fd_d.valid = 1'b1;
    end

    pipe_latch #(
        .W       (STAGE_W),
        .CLR_VAL (BUBBLE)
    ) u_fd_latch (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (act_advance),
        .clr_i (act_redirect),
        .d_i   (fd_d),
        .q_o   (fd_q)
    );

    // D/X takes a bubble on stall so the detector sees a non-load next cycle.
    pipe_latch #(
        .W       (STAGE_W),
        .CLR_VAL (BUBBLE)
    ) u_dx_latch (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (act_advance),
        .clr_i (act_redirect || act_stall),
        .d_i   (fd_q),
        .q_o   (dx_q)
    );

    // Saturating event counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (act_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (act_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_out    = pc_q;
    assign fd_ir     = fd_q.ir;
    assign fd_pc     = fd_q.pc;
    assign fd_valid  = fd_q.valid;
    assign dx_ir     = dx_q.ir;
    assign dx_pc     = dx_q.pc;
    assign dx_valid  = dx_q.valid;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fd_dx_pipe.sv
// tb/tb_fd_dx_pipe.sv - scoreboard bench for fd_dx_pipe with a behavioural reference model
module tb_fd_dx_pipe;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             is_stall = 1'b0;
    logic             md_busy = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_target = 32'h0;
    logic [31:0]      imem_q;
    logic [31:0]      pc_out, fd_ir, fd_pc, dx_ir, dx_pc;
    logic             fd_valid, dx_valid;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    fd_dx_pipe #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .is_stall      (is_stall),
        .md_busy       (md_busy),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_q        (imem_q),
        .pc_out        (pc_out),
        .fd_ir         (fd_ir),
        .fd_pc         (fd_pc),
        .fd_valid      (fd_valid),
        .dx_ir         (dx_ir),
        .dx_pc         (dx_pc),
        .dx_valid      (dx_valid),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clock = ~clock;

    // Instruction memory: word at address a holds 0x1000_0000 + a.
    assign imem_q = 32'h1000_0000 + pc_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] fd_ir, fd_pc;
        logic        fd_v;
        logic [31:0] dx_ir, dx_pc;
        logic        dx_v;
        int          sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a two-entry instruction list plus PC and event tallies.
    exp_t m;

    function automatic exp_t reset_state();
        exp_t r;
        r.pc = 32'h0; r.fd_ir = 32'h0; r.fd_pc = 32'h0; r.fd_v = 1'b0;
        r.dx_ir = 32'h0; r.dx_pc = 32'h0; r.dx_v = 1'b0; r.sc = 0; r.fc = 0;
        return r;
    endfunction

    function automatic exp_t model_step(input exp_t s, input logic md, input logic bt,
                                        input logic [31:0] tgt, input logic st);
        exp_t n = s;
        if (md) begin
            return n;
        end
        if (bt) begin
            n.pc = tgt;
            n.fd_ir = 32'h0; n.fd_pc = 32'h0; n.fd_v = 1'b0;
            n.dx_ir = 32'h0; n.dx_pc = 32'h0; n.dx_v = 1'b0;
            n.fc = (s.fc < CMAX) ? s.fc + 1 : CMAX;
        end else if (st) begin
            n.dx_ir = 32'h0; n.dx_pc = 32'h0; n.dx_v = 1'b0;
            n.sc = (s.sc < CMAX) ? s.sc + 1 : CMAX;
        end else begin
            n.dx_ir = s.fd_ir; n.dx_pc = s.fd_pc; n.dx_v = s.fd_v;
            n.fd_ir = mem_word(s.pc); n.fd_pc = s.pc; n.fd_v = 1'b1;
            n.pc = s.pc + 32'd1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every edge the DUT presents new latch contents; compare with the oldest prediction.
    always @(posedge clock) begin
        exp_t e;
        #2;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_out",    pc_out,             e.pc);
            chk("fd_ir",     fd_ir,              e.fd_ir);
            chk("fd_pc",     fd_pc,              e.fd_pc);
            chk("fd_valid",  {31'h0, fd_valid},  {31'h0, e.fd_v});
            chk("dx_ir",     dx_ir,              e.dx_ir);
            chk("dx_pc",     dx_pc,              e.dx_pc);
            chk("dx_valid",  {31'h0, dx_valid},  {31'h0, e.dx_v});
            chk("stall_cnt", 32'(stall_cnt),     32'(e.sc));
            chk("flush_cnt", 32'(flush_cnt),     32'(e.fc));
        end
    end

    task automatic cycle(input logic md, input logic bt, input logic [31:0] tgt, input logic st);
        @(negedge clock);
        md_busy = md; branch_taken = bt; branch_target = tgt; is_stall = st;
        m = model_step(m, md, bt, tgt, st);
        exp_q.push_back(m);
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #3;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},   pc_out, 32'h0);
        chk({tag, "_fdir"}, fd_ir, 32'h0);
        chk({tag, "_fdv"},  {31'h0, fd_valid}, 32'h0);
        chk({tag, "_dxpc"}, dx_pc, 32'h0);
        chk({tag, "_dxv"},  {31'h0, dx_valid}, 32'h0);
        chk({tag, "_sc"},   32'(stall_cnt), 32'h0);
        chk({tag, "_fc"},   32'(flush_cnt), 32'h0);
    endtask

    initial begin
        m = reset_state();
        #2;
        check_reset_values("rst0");
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(model_step(m, 1'b0, 1'b0, 32'h0, 1'b0));
        m = exp_q[exp_q.size()-1];

        // Free run: four edges total
        advance(3);
        after_edge();
        chk("run_fd_ir", fd_ir, 32'h1000_0003);
        chk("run_dx_ir", dx_ir, 32'h1000_0002);
        chk("run_pc",    pc_out, 32'h4);

        // Load-use stall with fd_pc = 5
        advance(2);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        after_edge();
        chk("stall_pc",   pc_out, 32'h6);
        chk("stall_fdpc", fd_pc, 32'h5);
        chk("stall_dxv",  {31'h0, dx_valid}, 32'h0);
        chk("stall_cnt1", 32'(stall_cnt), 32'h1);
        advance(1);
        after_edge();
        chk("stall_dxpc", dx_pc, 32'h5);

        // Redirect with simultaneous stall
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        after_edge();
        chk("redir_pc", pc_out, 32'h40);
        chk("redir_fc", 32'(flush_cnt), 32'h1);
        chk("redir_sc", 32'(stall_cnt), 32'h1);
        advance(1);
        after_edge();
        chk("redir_fdpc", fd_pc, 32'h40);
        advance(2);

        // Freeze for three cycles with a pending redirect
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h0000_0080, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0);
        after_edge();
        chk("frz_pc", pc_out, 32'h80);
        advance(2);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        after_edge();
        chk("sat_sc", 32'(stall_cnt), 32'hF);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        advance(2);
        after_edge();
        chk("wrap_pc", pc_out, 32'h0);
        chk("wrap_fdpc", fd_pc, 32'hFFFF_FFFF);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic md, bt, st;
            md = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 4) == 0);
            cycle(md, bt, $urandom, st);
        end
        after_edge();

        // Asynchronous reset between edges during a stall
        @(negedge clock);
        is_stall = 1'b1; md_busy = 1'b0; branch_taken = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("arst");
        @(negedge clock);
        reset = 1'b0;
        is_stall = 1'b0;
        m = reset_state();
        m = model_step(m, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(m);
        after_edge();
        chk("arst_sc", 32'(stall_cnt), 32'h0);
        chk("arst_pc", pc_out, 32'h1);
        advance(5);
        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 3) == 0));
        end
        after_edge();
        after_edge();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
